// File: rtl/acc_io_pkg.sv
// Shared definitions for the accumulator / IO register block: default widths,
// datapath command codes in priority order, and the FIFO count-width helper.
package acc_io_pkg;

    localparam int DEF_DW     = 18;
    localparam int DEF_OPW    = 3;
    localparam int DEF_AC_RST = 54;

    // Listed from highest to lowest priority; CMD_NONE means no enable is active.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_RD_INPR,
        CMD_WR_OUTR,
        CMD_RD_AC,
        CMD_WR_AC,
        CMD_RD_IR,
        CMD_WR_IR
    } cmd_e;

    function automatic int cntWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/acc_io_regfile_sync_fifo.sv
// Single-clock FIFO with head-of-queue read data and an occupancy count.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo import acc_io_pkg::*; #(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wdata,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [cntWidth(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cntWidth(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          doPush, doPop;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = mem_q[rdPtr_q];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap without extra logic.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && doPush) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/acc_io_regfile.sv
// IR/AC register block with a registered read bus and handshaked input/output
// FIFOs; one datapath command per cycle, chosen by fixed priority.
module acc_io_regfile import acc_io_pkg::*; #(
    parameter int DW        = DEF_DW,
    parameter int OPW       = DEF_OPW,
    parameter int AC_RST    = DEF_AC_RST,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DW-1:0]                  inD,
    output logic [DW-1:0]                  ouD,
    input  logic                           re_en_inpr,
    input  logic                           wr_en_outr,
    input  logic                           re_en_ac,
    input  logic                           wr_en_ac,
    input  logic                           re_en_ir,
    input  logic                           wr_en_ir,
    output logic [OPW-1:0]                 opcode,
    output logic                           flg_i,
    output logic                           flg_o,
    output logic                           ovf_o,
    input  logic [DW-1:0]                  in_intp,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DW-1:0]                  out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [cntWidth(IN_DEPTH)-1:0]  in_count,
    output logic [cntWidth(OUT_DEPTH)-1:0] out_count
);

    localparam int OCW = cntWidth(OUT_DEPTH);
    localparam logic [OCW-1:0] OUT_FULL = OCW'(OUT_DEPTH);

    cmd_e          cmd;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] ouD_q, ouD_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] inHead;
    logic          inFull, inEmpty, inPush, inPop;
    logic          outFull, outEmpty, outPush, outPop;

    always_comb begin
        cmd = CMD_NONE;
        if (re_en_inpr)      cmd = CMD_RD_INPR;
        else if (wr_en_outr) cmd = CMD_WR_OUTR;
        else if (re_en_ac)   cmd = CMD_RD_AC;
        else if (wr_en_ac)   cmd = CMD_WR_AC;
        else if (re_en_ir)   cmd = CMD_RD_IR;
        else if (wr_en_ir)   cmd = CMD_WR_IR;
    end

    assign inPush = in_valid && !inFull;
    assign outPop = !outEmpty && out_ready;

    // An empty input FIFO reads as zero on the bus; a blocked output write sets the sticky overflow.
    always_comb begin
        ac_d     = ac_q;
        ir_d     = ir_q;
        ouD_d    = ouD_q;
        ovf_d    = ovf_q;
        inPop    = 1'b0;
        outPush  = 1'b0;
        opcode_d = ir_q[DW-1 -: OPW];
        case (cmd)
            CMD_RD_INPR: begin
                inPop = !inEmpty;
                ouD_d = inEmpty ? '0 : inHead;
            end
            CMD_WR_OUTR: begin
                outPush = 1'b1;
                if (outFull && !outPop) begin
                    ovf_d = 1'b1;
                end
            end
            CMD_RD_AC: ouD_d = ac_q;
            CMD_WR_AC: ac_d  = inD;
            CMD_RD_IR: ouD_d = ir_q;
            CMD_WR_IR: ir_d  = inD;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q     <= DW'(AC_RST);
            ir_q     <= '0;
            ouD_q    <= '0;
            opcode_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ac_q     <= ac_d;
            ir_q     <= ir_d;
            ouD_q    <= ouD_d;
            opcode_q <= opcode_d;
            ovf_q    <= ovf_d;
        end
    end

    sync_fifo #(.DW(DW), .DEPTH(IN_DEPTH)) u_inFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inPush),
        .pop   (inPop),
        .wdata (in_intp),
        .rdata (inHead),
        .full  (inFull),
        .empty (inEmpty),
        .count (in_count)
    );

    sync_fifo #(.DW(DW), .DEPTH(OUT_DEPTH)) u_outFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (outPush),
        .pop   (outPop),
        .wdata (inD),
        .rdata (out_data),
        .full  (outFull),
        .empty (outEmpty),
        .count (out_count)
    );

    assign ouD       = ouD_q;
    assign opcode    = opcode_q;
    assign ovf_o     = ovf_q;
    assign in_ready  = !inFull;
    assign out_valid = !outEmpty;
    assign flg_i     = (in_count != '0);
    assign flg_o     = (out_count < OUT_FULL);

endmodule

// File: tb/tb_acc_io_regfile.sv
// Directed and randomized bench for acc_io_regfile, checked against a
// queue-based behavioural model of the register block and both FIFOs.
module tb_acc_io_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] inD;
    logic [17:0] ouD;
    logic        re_en_inpr, wr_en_outr, re_en_ac, wr_en_ac, re_en_ir, wr_en_ir;
    logic [2:0]  opcode;
    logic        flg_i, flg_o, ovf_o;
    logic [17:0] in_intp;
    logic        in_valid, in_ready;
    logic [17:0] out_data;
    logic        out_valid, out_ready;
    logic [2:0]  in_count, out_count;

    int total = 0;
    int bad   = 0;

    logic [17:0] mAc, mIr, mOuD;
    logic [2:0]  mOpc;
    logic        mOvf;
    logic [17:0] mInQ[$];
    logic [17:0] mOutQ[$];

    acc_io_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .inD        (inD),
        .ouD        (ouD),
        .re_en_inpr (re_en_inpr),
        .wr_en_outr (wr_en_outr),
        .re_en_ac   (re_en_ac),
        .wr_en_ac   (wr_en_ac),
        .re_en_ir   (re_en_ir),
        .wr_en_ir   (wr_en_ir),
        .opcode     (opcode),
        .flg_i      (flg_i),
        .flg_o      (flg_o),
        .ovf_o      (ovf_o),
        .in_intp    (in_intp),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .in_count   (in_count),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        rst = 1'b0; inD = '0; in_intp = '0; in_valid = 1'b0; out_ready = 1'b0;
        re_en_inpr = 1'b0; wr_en_outr = 1'b0; re_en_ac = 1'b0;
        wr_en_ac = 1'b0; re_en_ir = 1'b0; wr_en_ir = 1'b0;
    endtask

    // Behavioural model: one clock edge applied to the currently driven inputs.
    task automatic modelStep();
        bit          inReadyNow, outPopNow, pushOut;
        logic [17:0] tmp;
        if (rst) begin
            mAc = 18'd54; mIr = '0; mOuD = '0; mOpc = '0; mOvf = 1'b0;
            mInQ.delete(); mOutQ.delete();
            return;
        end
        inReadyNow = (mInQ.size() < 4);
        outPopNow  = (mOutQ.size() != 0) && out_ready;
        pushOut    = 1'b0;
        mOpc       = mIr[17:15];
        if (re_en_inpr) begin
            if (mInQ.size() != 0) mOuD = mInQ.pop_front();
            else                  mOuD = '0;
        end else if (wr_en_outr) begin
            if (mOutQ.size() < 4 || outPopNow) pushOut = 1'b1;
            else                               mOvf = 1'b1;
        end else if (re_en_ac) mOuD = mAc;
        else if (wr_en_ac)     mAc  = inD;
        else if (re_en_ir)     mOuD = mIr;
        else if (wr_en_ir)     mIr  = inD;
        if (outPopNow) tmp = mOutQ.pop_front();
        if (pushOut) mOutQ.push_back(inD);
        if (in_valid && inReadyNow) mInQ.push_back(in_intp);
    endtask

    task automatic checkOutput();
        checkVal("ouD", 32'(ouD), 32'(mOuD));
        checkVal("opcode", 32'(opcode), 32'(mOpc));
        checkVal("ovf_o", 32'(ovf_o), 32'(mOvf));
        checkVal("in_count", 32'(in_count), mInQ.size());
        checkVal("out_count", 32'(out_count), mOutQ.size());
        checkVal("flg_i", 32'(flg_i), 32'(mInQ.size() != 0));
        checkVal("flg_o", 32'(flg_o), 32'(mOutQ.size() < 4));
        checkVal("in_ready", 32'(in_ready), 32'(mInQ.size() < 4));
        checkVal("out_valid", 32'(out_valid), 32'(mOutQ.size() != 0));
        if (mOutQ.size() != 0) checkVal("out_data", 32'(out_data), 32'(mOutQ[0]));
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        idleInputs();
        @(negedge clk);

        // Reset with every enable and handshake asserted.
        rst = 1'b1; re_en_inpr = 1; wr_en_outr = 1; re_en_ac = 1; wr_en_ac = 1;
        re_en_ir = 1; wr_en_ir = 1; in_valid = 1; out_ready = 1;
        inD = 18'h3FFFF; in_intp = 18'h1234;
        applyStimulus();
        applyStimulus();
        checkVal("rst_ouD", 32'(ouD), 0);
        checkVal("rst_in_ready", 32'(in_ready), 1);
        checkVal("rst_out_valid", 32'(out_valid), 0);
        checkVal("rst_flg_o", 32'(flg_o), 1);

        idleInputs(); re_en_ac = 1;
        applyStimulus();
        checkVal("ac_reset_read", 32'(ouD), 54);

        // IR write and delayed opcode.
        idleInputs(); wr_en_ir = 1; inD = 18'h2A5F3;
        applyStimulus();
        idleInputs();
        applyStimulus();
        checkVal("opcode_lag", 32'(opcode), 3'b101);
        re_en_ir = 1;
        applyStimulus();
        checkVal("ir_read", 32'(ouD), 18'h2A5F3);

        // Priority: only the AC read executes.
        idleInputs(); re_en_ac = 1; wr_en_ac = 1; wr_en_ir = 1; inD = 18'd7;
        applyStimulus();
        checkVal("prio_ouD", 32'(ouD), 54);
        idleInputs(); re_en_ac = 1;
        applyStimulus();
        checkVal("prio_ac_kept", 32'(ouD), 54);
        idleInputs(); re_en_ir = 1;
        applyStimulus();
        checkVal("prio_ir_kept", 32'(ouD), 18'h2A5F3);

        // Input FIFO fill, overfill attempt, drain and empty read.
        idleInputs(); in_valid = 1;
        for (int i = 1; i <= 5; i++) begin
            in_intp = 18'(i);
            applyStimulus();
        end
        checkVal("in_full_ready", 32'(in_ready), 0);
        checkVal("in_full_count", 32'(in_count), 4);
        idleInputs();
        for (int i = 1; i <= 4; i++) begin
            re_en_inpr = 1;
            applyStimulus();
            checkVal("in_pop", 32'(ouD), i);
        end
        checkVal("in_drained_flg", 32'(flg_i), 0);
        applyStimulus();
        checkVal("in_empty_pop", 32'(ouD), 0);

        // Output FIFO overflow then drain.
        idleInputs(); wr_en_outr = 1;
        for (int i = 10; i <= 14; i++) begin
            inD = 18'(i);
            applyStimulus();
        end
        checkVal("out_full_count", 32'(out_count), 4);
        checkVal("out_ovf", 32'(ovf_o), 1);
        checkVal("out_full_flg", 32'(flg_o), 0);
        idleInputs(); out_ready = 1;
        for (int i = 10; i <= 13; i++) begin
            checkVal("out_head", 32'(out_data), i);
            applyStimulus();
        end

        // Full output FIFO with simultaneous push and pop; overflow must stay clear.
        idleInputs(); rst = 1;
        applyStimulus();
        idleInputs(); wr_en_outr = 1;
        for (int i = 20; i <= 23; i++) begin
            inD = 18'(i);
            applyStimulus();
        end
        inD = 18'd99; out_ready = 1;
        applyStimulus();
        checkVal("pp_count", 32'(out_count), 4);
        checkVal("pp_ovf", 32'(ovf_o), 0);
        idleInputs(); out_ready = 1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkVal("pp_last", 32'(out_data), 99);
        applyStimulus();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 79) == 0);
            re_en_inpr = ($urandom_range(0, 4) == 0);
            wr_en_outr = ($urandom_range(0, 3) == 0);
            re_en_ac   = ($urandom_range(0, 4) == 0);
            wr_en_ac   = ($urandom_range(0, 4) == 0);
            re_en_ir   = ($urandom_range(0, 4) == 0);
            wr_en_ir   = ($urandom_range(0, 4) == 0);
            in_valid   = ($urandom_range(0, 1) == 0);
            out_ready  = ($urandom_range(0, 2) == 0);
            inD        = 18'($urandom());
            in_intp    = 18'($urandom());
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
